// File: rtl/unidade_controle.sv
`default_nettype none
// ============================================================================
// Module   : unidade_controle
// Purpose  : Moore controller for the memory-game datapath. It starts a game
//            on iniciar, latches the game mode and walks each round r through
//            r+1 plays. The game ends in a win, a wrong play or a timeout.
// Ports    : clock        - system clock, rising edge
//            reset        - asynchronous, active-low
//            iniciar      - start/restart request (level)
//            modo_in      - mode switch (1 = 4 rounds, 0 = 16 rounds)
//            jogada_feita - one-cycle play pulse from the datapath
//            igual, fimRodada, fimTotal, fimT - datapath status
//            modo         - latched mode
//            zeraL/contaCL/zeraC/contaC/zeraR/registraR/conta - datapath ctrl
//            pronto/ganhou/perdeu/timeout - end-of-game status
//            db_estado    - current state code
// Revision : 1.0 - initial release
// ============================================================================
module unidade_controle #(
   parameter bit TIMEOUT_EN = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       modo_in,
   input  logic       jogada_feita,
   input  logic       igual,
   input  logic       fimRodada,
   input  logic       fimTotal,
   input  logic       fimT,
   output logic       modo,
   output logic       zeraL,
   output logic       contaCL,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       conta,
   output logic       pronto,
   output logic       ganhou,
   output logic       perdeu,
   output logic       timeout,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL        = 4'h0,
      PREPARACAO     = 4'h1,
      INICIO_RODADA  = 4'h2,
      ESPERA_JOGADA  = 4'h3,
      REGISTRA       = 4'h4,
      COMPARACAO     = 4'h5,
      PROXIMA_JOGADA = 4'h6,
      PROXIMA_RODADA = 4'h7,
      FIM_ACERTOU    = 4'hA,
      FIM_ERROU      = 4'hE,
      FIM_TIMEOUT    = 4'hD
   } estado_t;

   // Control vector order:
   // {zeraL, contaCL, zeraC, contaC, zeraR, registraR, conta,
   //  pronto, ganhou, perdeu, timeout}
   localparam logic [10:0] C_NONE  = 11'b000_0000_0000;
   localparam logic [10:0] C_PREP  = 11'b101_0100_0000;
   localparam logic [10:0] C_INIR  = 11'b001_0100_0000;
   localparam logic [10:0] C_ESP   = 11'b000_0001_0000;
   localparam logic [10:0] C_REG   = 11'b000_0010_0000;
   localparam logic [10:0] C_PJOG  = 11'b000_1000_0000;
   localparam logic [10:0] C_PROD  = 11'b010_0000_0000;
   localparam logic [10:0] C_WIN   = 11'b000_0000_1100;
   localparam logic [10:0] C_ERR   = 11'b000_0000_1010;
   localparam logic [10:0] C_TOUT  = 11'b000_0000_1001;

   estado_t     r_estado;
   estado_t     w_prox;
   logic        r_modo;
   logic [10:0] r_ctrl;
   logic        w_ocioso;

   function automatic logic [10:0] decodifica(input estado_t e);
      case (e)
         PREPARACAO:     decodifica = C_PREP;
         INICIO_RODADA:  decodifica = C_INIR;
         ESPERA_JOGADA:  decodifica = C_ESP;
         REGISTRA:       decodifica = C_REG;
         PROXIMA_JOGADA: decodifica = C_PJOG;
         PROXIMA_RODADA: decodifica = C_PROD;
         FIM_ACERTOU:    decodifica = C_WIN;
         FIM_ERROU:      decodifica = C_ERR;
         FIM_TIMEOUT:    decodifica = C_TOUT;
         default:        decodifica = C_NONE;
      endcase
   endfunction

   // States in which iniciar is honoured (idle and all end states).
   assign w_ocioso = (r_estado == INICIAL)     || (r_estado == FIM_ACERTOU) ||
                     (r_estado == FIM_ERROU)   || (r_estado == FIM_TIMEOUT);

   always_comb begin
      w_prox = r_estado;
      case (r_estado)
         INICIAL:        if (iniciar) w_prox = PREPARACAO;
         PREPARACAO:     w_prox = INICIO_RODADA;
         INICIO_RODADA:  w_prox = ESPERA_JOGADA;
         ESPERA_JOGADA: begin
            // A play arriving together with the timeout terminal wins.
            if (jogada_feita)            w_prox = REGISTRA;
            else if (fimT && TIMEOUT_EN) w_prox = FIM_TIMEOUT;
         end
         REGISTRA:       w_prox = COMPARACAO;
         COMPARACAO: begin
            if (!igual)          w_prox = FIM_ERROU;
            else if (!fimRodada) w_prox = PROXIMA_JOGADA;
            else if (!fimTotal)  w_prox = PROXIMA_RODADA;
            else                 w_prox = FIM_ACERTOU;
         end
         PROXIMA_JOGADA: w_prox = ESPERA_JOGADA;
         PROXIMA_RODADA: w_prox = INICIO_RODADA;
         FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                         if (iniciar) w_prox = PREPARACAO;
         default:        w_prox = INICIAL;
      endcase
   end

   // Outputs are decoded from the next state so that they are registered
   // yet still line up exactly with the state they belong to.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado <= INICIAL;
         r_ctrl   <= C_NONE;
         r_modo   <= 1'b0;
      end else begin
         r_estado <= w_prox;
         r_ctrl   <= decodifica(w_prox);
         if (w_ocioso && iniciar)
            r_modo <= modo_in;
      end
   end

   assign modo      = r_modo;
   assign zeraL     = r_ctrl[10];
   assign contaCL   = r_ctrl[9];
   assign zeraC     = r_ctrl[8];
   assign contaC    = r_ctrl[7];
   assign zeraR     = r_ctrl[6];
   assign registraR = r_ctrl[5];
   assign conta     = r_ctrl[4];
   assign pronto    = r_ctrl[3];
   assign ganhou    = r_ctrl[2];
   assign perdeu    = r_ctrl[1];
   assign timeout   = r_ctrl[0];
   assign db_estado = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle.sv
`default_nettype none
// ============================================================================
// Module   : tb_unidade_controle
// Purpose  : Scoreboard bench for unidade_controle. The driver pushes the
//            expected state/output vector after each clock step; a monitor
//            pops and compares on the falling edge. A second instance with
//            TIMEOUT_EN=0 shares the inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unidade_controle;

   logic clock = 1'b0;
   logic reset, iniciar, modo_in, jogada_feita, igual, fimRodada, fimTotal, fimT;

   logic       modo, zeraL, contaCL, zeraC, contaC, zeraR, registraR, conta;
   logic       pronto, ganhou, perdeu, timeout;
   logic [3:0] db_estado;
   logic       modo2, zeraL2, contaCL2, zeraC2, contaC2, zeraR2, registraR2, conta2;
   logic       pronto2, ganhou2, perdeu2, timeout2;
   logic [3:0] db_estado2;

   always #5 clock = ~clock;

   unidade_controle #(.TIMEOUT_EN(1'b1)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .modo_in(modo_in),
      .jogada_feita(jogada_feita), .igual(igual), .fimRodada(fimRodada),
      .fimTotal(fimTotal), .fimT(fimT), .modo(modo), .zeraL(zeraL),
      .contaCL(contaCL), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
      .registraR(registraR), .conta(conta), .pronto(pronto), .ganhou(ganhou),
      .perdeu(perdeu), .timeout(timeout), .db_estado(db_estado)
   );

   unidade_controle #(.TIMEOUT_EN(1'b0)) dut2 (
      .clock(clock), .reset(reset), .iniciar(iniciar), .modo_in(modo_in),
      .jogada_feita(jogada_feita), .igual(igual), .fimRodada(fimRodada),
      .fimTotal(fimTotal), .fimT(fimT), .modo(modo2), .zeraL(zeraL2),
      .contaCL(contaCL2), .zeraC(zeraC2), .contaC(contaC2), .zeraR(zeraR2),
      .registraR(registraR2), .conta(conta2), .pronto(pronto2), .ganhou(ganhou2),
      .perdeu(perdeu2), .timeout(timeout2), .db_estado(db_estado2)
   );

   // {modo, zeraL, contaCL, zeraC, contaC, zeraR, registraR, conta,
   //  pronto, ganhou, perdeu, timeout}
   logic [11:0] w_vec, w_vec2;
   assign w_vec  = {modo, zeraL, contaCL, zeraC, contaC, zeraR, registraR, conta,
                    pronto, ganhou, perdeu, timeout};
   assign w_vec2 = {modo2, zeraL2, contaCL2, zeraC2, contaC2, zeraR2, registraR2, conta2,
                    pronto2, ganhou2, perdeu2, timeout2};

   typedef struct {
      string      name;
      bit         sel;
      logic [3:0] est;
      logic [11:0] outs;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cnt_cl = 0;
   bit   exp_modo = 1'b0;

   // Hand-written output table per state code.
   function automatic logic [11:0] outs_for(input logic [3:0] e, input bit m);
      logic [11:0] r;
      case (e)
         4'h1:    r = 12'h540;   // zeraL zeraC zeraR
         4'h2:    r = 12'h140;   // zeraC zeraR
         4'h3:    r = 12'h010;   // conta
         4'h4:    r = 12'h020;   // registraR
         4'h6:    r = 12'h080;   // contaC
         4'h7:    r = 12'h200;   // contaCL
         4'hA:    r = 12'h00C;   // pronto ganhou
         4'hE:    r = 12'h00A;   // pronto perdeu
         4'hD:    r = 12'h009;   // pronto timeout
         default: r = 12'h000;
      endcase
      return r | {m, 11'b0};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_st(input string n, input logic [3:0] e);
      exp_t x;
      x.name = n; x.sel = 1'b0; x.est = e; x.outs = outs_for(e, exp_modo);
      q.push_back(x);
   endtask

   task automatic expect_st2(input string n, input logic [3:0] e);
      exp_t x;
      x.name = n; x.sel = 1'b1; x.est = e; x.outs = outs_for(e, exp_modo);
      q.push_back(x);
   endtask

   // Monitor: compares every queued expectation on the falling edge.
   initial begin
      exp_t e;
      logic [3:0]  a_est;
      logic [11:0] a_vec;
      forever begin
         @(negedge clock);
         if (contaCL) cnt_cl++;
         while (q.size() > 0) begin
            e = q.pop_front();
            a_est = e.sel ? db_estado2 : db_estado;
            a_vec = e.sel ? w_vec2 : w_vec;
            checks++;
            if (a_est !== e.est || a_vec !== e.outs) begin
               errors++;
               $display("FAIL %s: got estado=%h outs=%b, expected estado=%h outs=%b",
                        e.name, a_est, a_vec, e.est, e.outs);
            end
         end
      end
   end

   initial begin
      reset = 1'b0; iniciar = 1'b0; modo_in = 1'b0; jogada_feita = 1'b0;
      igual = 1'b0; fimRodada = 1'b0; fimTotal = 1'b0; fimT = 1'b0;
      step(); step();
      expect_st("reset_state", 4'h0);
      expect_st2("reset_state2", 4'h0);
      step();
      reset = 1'b1;
      step();
      expect_st("idle_no_start", 4'h0);

      // ---- Full win, 4-round mode ----
      iniciar = 1'b1; modo_in = 1'b1;
      step(); exp_modo = 1'b1; expect_st("win_prep", 4'h1);
      iniciar = 1'b0;
      step(); expect_st("win_inicio", 4'h2);
      step(); expect_st("win_espera", 4'h3);
      for (int r = 0; r < 4; r++) begin
         for (int p = 0; p <= r; p++) begin
            jogada_feita = 1'b1;
            step(); expect_st("win_registra", 4'h4);
            jogada_feita = 1'b0;
            igual = 1'b1; fimRodada = (p == r); fimTotal = (r == 3);
            step(); expect_st("win_comparacao", 4'h5);
            step();
            igual = 1'b0; fimRodada = 1'b0; fimTotal = 1'b0;
            if (p < r) begin
               expect_st("win_prox_jogada", 4'h6);
               step(); expect_st("win_espera_j", 4'h3);
            end else if (r < 3) begin
               expect_st("win_prox_rodada", 4'h7);
               step(); expect_st("win_inicio_r", 4'h2);
               step(); expect_st("win_espera_r", 4'h3);
            end else begin
               expect_st("win_fim_acertou", 4'hA);
            end
         end
      end
      step(); expect_st("win_hold", 4'hA);
      checks++;
      if (cnt_cl != 3) begin
         errors++;
         $display("FAIL contaCL_pulses: got %0d, expected 3", cnt_cl);
      end

      // ---- Wrong play in round 1, mode latch with modo_in=0 ----
      iniciar = 1'b1; modo_in = 1'b0;
      step(); exp_modo = 1'b0; expect_st("err_prep", 4'h1);
      iniciar = 1'b0;
      step(); expect_st("err_inicio", 4'h2);
      step(); expect_st("err_espera", 4'h3);
      jogada_feita = 1'b1;
      step(); jogada_feita = 1'b0; expect_st("err_reg0", 4'h4);
      igual = 1'b1; fimRodada = 1'b1;
      step(); expect_st("err_cmp0", 4'h5);
      step(); igual = 1'b0; fimRodada = 1'b0; expect_st("err_prox_rodada", 4'h7);
      modo_in = 1'b1;   // toggled mid-game: must not reach modo
      step(); expect_st("err_inicio1", 4'h2);
      step(); expect_st("err_espera1", 4'h3);
      jogada_feita = 1'b1;
      step(); jogada_feita = 1'b0; expect_st("err_reg1a", 4'h4);
      igual = 1'b1;
      step(); expect_st("err_cmp1a", 4'h5);
      step(); igual = 1'b0; expect_st("err_prox_jogada", 4'h6);
      step(); expect_st("err_espera1b", 4'h3);
      iniciar = 1'b1;   // ignored mid-game
      jogada_feita = 1'b1;
      step(); jogada_feita = 1'b0; iniciar = 1'b0; expect_st("err_reg1b", 4'h4);
      step(); expect_st("err_cmp1b", 4'h5);
      step(); expect_st("err_fim_errou", 4'hE);
      step(); expect_st("err_hold", 4'hE);

      // ---- Restart with modo_in=1, tie case ----
      iniciar = 1'b1;
      step(); exp_modo = 1'b1; expect_st("rst_prep", 4'h1);
      iniciar = 1'b0;
      step(); expect_st("rst_inicio", 4'h2);
      step(); expect_st("rst_espera", 4'h3);
      jogada_feita = 1'b1; fimT = 1'b1;
      step(); jogada_feita = 1'b0; fimT = 1'b0; expect_st("tie_registra", 4'h4);
      igual = 1'b1;
      step(); expect_st("tie_comparacao", 4'h5);
      step(); igual = 1'b0; expect_st("tie_prox_jogada", 4'h6);
      step(); expect_st("tie_espera", 4'h3);

      // ---- Timeout, both TIMEOUT_EN settings ----
      fimT = 1'b1;
      step(); fimT = 1'b0;
      expect_st("to_fim_timeout", 4'hD);
      expect_st2("to_disabled_stays", 4'h3);
      step(); expect_st("to_hold", 4'hD);

      // ---- Asynchronous reset mid espera_jogada ----
      iniciar = 1'b1;
      step(); expect_st("ar_prep", 4'h1);
      iniciar = 1'b0;
      step(); step(); expect_st("ar_espera", 4'h3);
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      exp_modo = 1'b0;
      expect_st("async_reset", 4'h0);
      expect_st2("async_reset2", 4'h0);
      step(); step(); expect_st("reset_held", 4'h0);
      reset = 1'b1;
      step(); expect_st("release_idle", 4'h0);
      step(); expect_st("release_idle2", 4'h0);

      repeat (2) @(negedge clock);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Moore FSM that sequences the memory-game datapath (round counter, play counter, play register, sync ROM, play comparator, timeout counter).
- Starts a game on iniciar and latches the game mode.
- Each round r requires r+1 correct plays; the game ends with win, error or timeout.
- Sits between the top level and fluxo_dados; drives every datapath control input and consumes its status outputs.

Parameters:
TIMEOUT_EN, 1, 1 = fimT in espera_jogada ends game with timeout; 0 = fimT ignored

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; reset=0 forces inicial immediately
iniciar  input  1  level, start/restart request
modo_in  input  1  mode switch (1 = 4 rounds, 0 = 16 rounds)
jogada_feita  input  1  one-cycle pulse from datapath edge detector
igual  input  1  ROM data == registered play
fimRodada  input  1  play address == current round index
fimTotal  input  1  round index == last round for latched mode
fimT  input  1  timeout counter terminal
modo  output  1  latched mode to datapath mux
zeraL  output  1  clear round counter
contaCL  output  1  increment round counter
zeraC  output  1  clear play counter (also clears timeout counter and edge detector)
contaC  output  1  increment play counter
zeraR  output  1  clear play register
registraR  output  1  load play register
conta  output  1  enable timeout counter
pronto  output  1  game finished
ganhou  output  1  finished by win
perdeu  output  1  finished by wrong play
timeout  output  1  finished by timeout
db_estado  output  4  current state code

Behaviour:
- States/codes: inicial 0x0, preparacao 0x1, inicio_rodada 0x2, espera_jogada 0x3, registra 0x4, comparacao 0x5, proxima_jogada 0x6, proxima_rodada 0x7, fim_acertou 0xA, fim_errou 0xE, fim_timeout 0xD. Any other code goes to inicial on the next edge.
- Transitions:
  - inicial: iniciar -> preparacao.
  - preparacao -> inicio_rodada.
  - inicio_rodada -> espera_jogada.
  - espera_jogada: jogada_feita -> registra; else fimT && TIMEOUT_EN -> fim_timeout; else stay.
  - registra -> comparacao.
  - comparacao: !igual -> fim_errou; igual && !fimRodada -> proxima_jogada; igual && fimRodada && !fimTotal -> proxima_rodada; igual && fimRodada && fimTotal -> fim_acertou.
  - proxima_jogada -> espera_jogada.
  - proxima_rodada -> inicio_rodada.
  - fim_*: iniciar -> preparacao; else hold.
- Outputs are decoded from state only (Moore); none is combinational from inputs:
  - preparacao: zeraL=zeraC=zeraR=1.
  - inicio_rodada: zeraC=zeraR=1.
  - espera_jogada: conta=1.
  - registra: registraR=1.
  - proxima_jogada: contaC=1.
  - proxima_rodada: contaCL=1.
  - fim_acertou: pronto=ganhou=1.
  - fim_errou: pronto=perdeu=1.
  - fim_timeout: pronto=timeout=1.
  - All other outputs are 0 in every state.
- modo register: loads modo_in on the edge leaving inicial or any fim_* state when iniciar=1. It holds during the game, so modo_in changes mid-game have no effect. Reset value 0.
- Reset: state=inicial, modo=0, all control/status outputs 0, db_estado=0x0. Reset mid-game aborts immediately, asynchronously.
- Latency:
  - jogada_feita to registraR: 1 cycle.
  - Comparison is evaluated one cycle after registraR, so the register output is valid.
  - After contaC, at least one espera_jogada cycle elapses before any compare, which covers the sync ROM read latency.
- Simultaneous jogada_feita and fimT in espera_jogada: the play wins (-> registra).
- iniciar is ignored in all non-idle, non-final states. Holding iniciar high in a fim_* state restarts on the next edge.
- The timeout counter is cleared by the datapath on zeraC or jogada_feita; the controller gates only conta.

Test Plan:
- Reset: reset=0 mid-espera_jogada -> db_estado=0x0 at once, all outputs 0; release with iniciar=0 -> stays 0x0.
- Full win, modo_in=1: iniciar pulse, then correct plays for rounds 0..3 (1+2+3+4=10 plays) -> exactly 3 contaCL pulses, final db_estado=0xA, pronto=ganhou=1, perdeu=timeout=0.
- Wrong play: round 1, second play with igual=0 in comparacao -> db_estado=0xE, pronto=perdeu=1; iniciar -> preparacao with zeraL=zeraC=zeraR=1 for one cycle.
- Timeout: no jogada_feita, fimT=1 while in espera_jogada -> next state 0xD, timeout=pronto=1. With TIMEOUT_EN=0 -> remains 0x3.
- Tie: jogada_feita=fimT=1 in the same cycle -> 0x4 (registra), registraR=1 for exactly one cycle.
- Mode latch: start with modo_in=0, toggle modo_in to 1 during round 2 -> modo output stays 0 until the next start from a fim_* state.
